// File: rtl/contention_ctl.sv
// contention_ctl: stretches the CPU clock while the screen fetcher owns video RAM.
// Latency: clkcpu, stall and vid_slot are registered, one clk14 behind their inputs.
// Backpressure: a contended request inside a fetch window holds clkcpu high in whole T-states.
//
// Ports:
//   clk14, rst_n            14 MHz master clock, asynchronous active-low reset
//   hc0, vc                 screen timing counters (hc = hc0[9:1], hc0[1] = CPU clock phase)
//   a15, a14, a0            CPU address bits used for contention decode
//   n_mreq, n_iorq, n_rfsh  Z80 strobes, active-low
//   rambank                 bank paged at 0xC000
//   cont_en                 contention enable
//   clkcpu                  CPU clock output
//   stall                   high while the CPU clock is frozen
//   vid_slot                registered screen-fetch window flag
module contention_ctl #(
    parameter int V_AREA       = 192,
    parameter int H_AREA       = 256,
    parameter int CONT_ADVANCE = 0
) (
    input  logic       clk14,
    input  logic       rst_n,
    input  logic [9:0] hc0,
    input  logic [8:0] vc,
    input  logic       a15,
    input  logic       a14,
    input  logic       a0,
    input  logic       n_mreq,
    input  logic       n_iorq,
    input  logic       n_rfsh,
    input  logic [2:0] rambank,
    input  logic       cont_en,
    output logic       clkcpu,
    output logic       stall,
    output logic       vid_slot
);

    localparam logic [8:0] V_AREA_L  = 9'(V_AREA);
    localparam logic [8:0] H_AREA_L  = 9'(H_AREA);
    localparam logic [8:0] ADVANCE_L = 9'(CONT_ADVANCE);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        SERVED = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       clkcpu_q, clkcpu_d;
    logic       stall_q, stall_d;
    logic       vid_slot_q;

    logic [8:0] hc;
    logic [8:0] hc_a;
    logic       win;
    logic       addr_cont;
    logic       req;
    logic       dp;

    // Only the bank parity marks a contended page; the pixel LSB of hc0
    // carries no timing information at this granularity.
    logic       unused_bits;
    assign unused_bits = ^{rambank[2:1], hc0[0]};

    assign hc   = hc0[9:1];
    assign hc_a = hc + ADVANCE_L;  // 9-bit wrap is intentional

    // Fetcher owns the first 12 pixels of every 16-pixel group on active area.
    assign win = (vc < V_AREA_L) && (hc_a < H_AREA_L) && (hc_a[3:0] < 4'd12);

    // Bank 5 at 0x4000, odd banks at 0xC000.
    assign addr_cont = (~a15 & a14) | (a15 & a14 & rambank[0]);

    assign req = cont_en & n_rfsh & ((~n_mreq & addr_cont) | (~n_iorq & ~a0));

    // Last clk14 of the high CPU phase: the decision made here lands on the
    // edge just before clkcpu would otherwise fall.
    assign dp = (hc0[1:0] == 2'b11);

    // State register
    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            clkcpu_q   <= 1'b0;
            stall_q    <= 1'b0;
            vid_slot_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clkcpu_q   <= clkcpu_d;
            stall_q    <= stall_d;
            vid_slot_q <= win;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (dp && req) begin
                    state_d = win ? STALL : SERVED;
                end
            end
            STALL: begin
                // A dropped request does not end the stall; losing the enable
                // does, but still only on a T-state boundary.
                if (dp && (!win || !cont_en)) begin
                    state_d = SERVED;
                end
            end
            SERVED: begin
                // Stay here until the access ends so it is stretched only once.
                if (n_mreq && n_iorq) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Output logic: in STALL the clock is pinned high; elsewhere it tracks the
    // free-running phase, so release keeps the original CPU clock phase.
    always_comb begin
        clkcpu_d = hc0[1];
        stall_d  = 1'b0;
        if (state_q == STALL) begin
            clkcpu_d = 1'b1;
            stall_d  = 1'b1;
        end
    end

    assign clkcpu   = clkcpu_q;
    assign stall    = stall_q;
    assign vid_slot = vid_slot_q;

endmodule

// File: tb/tb_contention_ctl.sv
module tb_contention_ctl;

    logic       clk14 = 1'b0;
    logic       rst_n;
    logic [9:0] hc0;
    logic [8:0] vc;
    logic       a15, a14, a0;
    logic       n_mreq, n_iorq, n_rfsh;
    logic [2:0] rambank;
    logic       cont_en;
    logic       clkcpu, stall, vid_slot;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_q[$];

    logic prev_hc1 = 1'b0;
    logic prev_win = 1'b0;

    always #5 clk14 = ~clk14;

    contention_ctl dut (
        .clk14    (clk14),
        .rst_n    (rst_n),
        .hc0      (hc0),
        .vc       (vc),
        .a15      (a15),
        .a14      (a14),
        .a0       (a0),
        .n_mreq   (n_mreq),
        .n_iorq   (n_iorq),
        .n_rfsh   (n_rfsh),
        .rambank  (rambank),
        .cont_en  (cont_en),
        .clkcpu   (clkcpu),
        .stall    (stall),
        .vid_slot (vid_slot)
    );

    // Reference fetch window for the default parameters.
    function automatic logic model_win(input logic [9:0] h0, input logic [8:0] v);
        logic [8:0] h;
        h = h0[9:1];
        return (v < 9'd192) && (h < 9'd256) && (h[3:0] < 4'd12);
    endfunction

    // Expected stall in clk14 cycles for an access whose T-state starts at
    // pixel hc_start: one T-state per decision point that still sees the window.
    function automatic int model_stall(input int hc_start, input int v, input bit active);
        int n;
        int h;
        n = 0;
        if (!active) return 0;
        h = hc_start + 1;
        while (v < 192 && h < 256 && (h % 16) < 12) begin
            n++;
            h += 2;
        end
        return n * 4;
    endfunction

    // One clk14 cycle: outputs are sampled 1 time unit after the edge, and the
    // values the DUT saw at that edge are kept for the registered-output checks.
    task automatic tick();
        logic pw, ph;
        pw = model_win(hc0, vc);
        ph = hc0[1];
        @(posedge clk14);
        #1;
        prev_win = pw;
        prev_hc1 = ph;
        hc0      = hc0 + 10'd1;
    endtask

    // Align to hc0 == target, assert the strobe, hold it for 'hold' cycles,
    // optionally drop cont_en (kind 1) or the strobes (kind 2) after tick drop_at.
    task automatic run_access(input logic [9:0] target, input bit io, input int hold,
                              input int drop_at, input int drop_kind,
                              output int cnt, output bit clk_ok, output bit vid_ok);
        bit aligned;
        aligned = 1'b0;
        for (int i = 0; i < 2048 && !aligned; i++) begin
            if (hc0 == target) aligned = 1'b1;
            else tick();
        end
        cnt    = 0;
        clk_ok = 1'b1;
        vid_ok = 1'b1;
        if (!aligned) begin
            cnt = -1;
            return;
        end
        if (io) n_iorq = 1'b0;
        else    n_mreq = 1'b0;
        for (int i = 1; i <= hold + 8; i++) begin
            if (i == hold + 1) begin
                n_mreq = 1'b1;
                n_iorq = 1'b1;
            end
            tick();
            if (stall === 1'b1) begin
                cnt++;
                if (clkcpu !== 1'b1) clk_ok = 1'b0;
            end else if (clkcpu !== prev_hc1) begin
                clk_ok = 1'b0;
            end
            if (vid_slot !== prev_win) vid_ok = 1'b0;
            if (i == drop_at) begin
                if (drop_kind == 1) cont_en = 1'b0;
                else if (drop_kind == 2) begin
                    n_mreq = 1'b1;
                    n_iorq = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        bit trk_ok;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        if (clkcpu !== 1'b0) begin $display("FAIL reset_clkcpu got %b want 0", clkcpu); n_fail++; end
        n_assert++;
        if (stall !== 1'b0) begin $display("FAIL reset_stall got %b want 0", stall); n_fail++; end
        n_assert++;
        if (vid_slot !== 1'b0) begin $display("FAIL reset_vid_slot got %b want 0", vid_slot); n_fail++; end
        n_assert++;
        rst_n  = 1'b1;
        trk_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (clkcpu !== prev_hc1 || stall !== 1'b0) trk_ok = 1'b0;
        end
        if (trk_ok !== 1'b1) begin $display("FAIL reset_release_track got %b want 1", trk_ok); n_fail++; end
        n_assert++;
    endtask

    task automatic test_reset_mid_stall();
        bit reached, trk_ok;
        vc = 9'd10; a15 = 1'b0; a14 = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 2048 && hc0 != 10'd64; i++) tick();
        n_mreq = 1'b0;
        for (int i = 0; i < 64 && !reached; i++) begin
            tick();
            if (hc0 == 10'h05A) reached = 1'b1;
        end
        if (stall !== 1'b1 || !reached) begin
            $display("FAIL midreset_pre_stall got %b reached %b want 1", stall, reached); n_fail++;
        end
        n_assert++;
        rst_n = 1'b0;
        #1;
        if ({clkcpu, stall, vid_slot} !== 3'b000) begin
            $display("FAIL midreset_outputs got %b%b%b want 000", clkcpu, stall, vid_slot); n_fail++;
        end
        n_assert++;
        n_mreq = 1'b1;
        tick();
        tick();
        rst_n  = 1'b1;
        trk_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (clkcpu !== prev_hc1 || stall !== 1'b0) trk_ok = 1'b0;
        end
        if (trk_ok !== 1'b1) begin $display("FAIL midreset_resume got %b want 1", trk_ok); n_fail++; end
        n_assert++;
    endtask

    task automatic test_basic();
        int cnt, e;
        bit ck, vd;
        vc = 9'd10; a15 = 1'b0; a14 = 1'b1;
        exp_q.push_back(24);
        run_access(10'd0, 1'b0, 40, 0, 0, cnt, ck, vd);
        e = exp_q.pop_front();
        if (cnt !== e) begin $display("FAIL basic_stall_len got %0d want %0d", cnt, e); n_fail++; end
        n_assert++;
        if (ck !== 1'b1) begin $display("FAIL basic_clk_shape got %b want 1", ck); n_fail++; end
        n_assert++;
        if (vd !== 1'b1) begin $display("FAIL basic_vid_slot got %b want 1", vd); n_fail++; end
        n_assert++;
    endtask

    task automatic test_sweep();
        int tbl[8] = '{24, 20, 16, 12, 8, 4, 0, 0};
        int cnt, e;
        bit ck, vd;
        vc = 9'd50; a15 = 1'b0; a14 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(tbl[k]);
            run_access(10'(2 * (32 + 2 * k)), 1'b0, 40, 0, 0, cnt, ck, vd);
            e = exp_q.pop_front();
            if (cnt !== e || ck !== 1'b1) begin
                $display("FAIL sweep_hc%0d got %0d clk_ok %b want %0d", 2 * k, cnt, ck, e); n_fail++;
            end
            n_assert++;
        end
    endtask

    task automatic test_decode();
        // a15 a14 a0 rambank io expected
        logic [1:0] hi[5] = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
        logic       lo0[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] bk[5] = '{3'd4, 3'd5, 3'd5, 3'd0, 3'd0};
        bit         io[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int         ex[5] = '{0, 24, 0, 0, 24};
        int cnt, e;
        bit ck, vd;
        vc = 9'd10;
        for (int k = 0; k < 5; k++) begin
            a15 = hi[k][1]; a14 = hi[k][0]; a0 = lo0[k]; rambank = bk[k];
            exp_q.push_back(ex[k]);
            run_access(10'd64, io[k], 40, 0, 0, cnt, ck, vd);
            e = exp_q.pop_front();
            if (cnt !== e) begin $display("FAIL decode_case%0d got %0d want %0d", k, cnt, e); n_fail++; end
            n_assert++;
        end
        a0 = 1'b1; rambank = 3'd0;
    endtask

    task automatic test_exclusions();
        int cnt, e;
        bit ck, vd;
        a15 = 1'b0; a14 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vc = (k == 0) ? 9'd200 : 9'd10;
            cont_en = (k == 2) ? 1'b0 : 1'b1;
            n_rfsh  = (k == 3) ? 1'b0 : 1'b1;
            exp_q.push_back(model_stall((k == 1) ? 296 : 32, int'(vc), (k < 2)));
            run_access((k == 1) ? 10'd592 : 10'd64, 1'b0, 40, 0, 0, cnt, ck, vd);
            e = exp_q.pop_front();
            if (cnt !== e || vd !== 1'b1) begin
                $display("FAIL exclusion_case%0d got %0d vid_ok %b want %0d", k, cnt, vd, e); n_fail++;
            end
            n_assert++;
        end
        cont_en = 1'b1; n_rfsh = 1'b1;
    endtask

    task automatic test_back_to_back();
        int cnt, e;
        bit ck, vd;
        vc = 9'd10; a15 = 1'b0; a14 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(model_stall(32, 10, 1'b1));
            run_access(10'd64, 1'b0, 100, 0, 0, cnt, ck, vd);
            e = exp_q.pop_front();
            if (cnt !== e || ck !== 1'b1) begin
                $display("FAIL held_access%0d got %0d clk_ok %b want %0d", k, cnt, ck, e); n_fail++;
            end
            n_assert++;
        end
    endtask

    task automatic test_release_events();
        int cnt, e;
        bit ck, vd;
        vc = 9'd10; a15 = 1'b0; a14 = 1'b1;
        // Enable dropped mid-stall: released at the following decision point.
        exp_q.push_back(8);
        run_access(10'd64, 1'b0, 40, 8, 1, cnt, ck, vd);
        cont_en = 1'b1;
        e = exp_q.pop_front();
        if (cnt !== e) begin $display("FAIL cont_en_drop got %0d want %0d", cnt, e); n_fail++; end
        n_assert++;
        // Strobe dropped mid-stall: window still decides the release.
        exp_q.push_back(24);
        run_access(10'd64, 1'b0, 40, 8, 2, cnt, ck, vd);
        e = exp_q.pop_front();
        if (cnt !== e) begin $display("FAIL req_drop got %0d want %0d", cnt, e); n_fail++; end
        n_assert++;
    endtask

    initial begin
        rst_n = 1'b0; hc0 = 10'd0; vc = 9'd0;
        a15 = 1'b0; a14 = 1'b0; a0 = 1'b1;
        n_mreq = 1'b1; n_iorq = 1'b1; n_rfsh = 1'b1;
        rambank = 3'd0; cont_en = 1'b1;
        test_reset();
        test_basic();
        test_sweep();
        test_decode();
        test_exclusions();
        test_back_to_back();
        test_release_events();
        test_reset_mid_stall();
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); n_fail++;
        end
        n_assert++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/contention_ctl.md
# contention_ctl

Sequences CPU access to the shared video RAM against the screen fetcher by stretching the 3.5 MHz CPU clock. CPU memory cycles to contended banks and ULA I/O cycles (A0=0) that fall inside a screen-fetch window are stalled with the CPU clock held high. The stall is released at the first free slot. The block sits between the screen timing counters and the Z80 clock pin, and replaces the free-running `clkcpu` assignment.

## Interface
Parameters:
- `V_AREA`, 192, number of active screen lines; contention applies when `vc < V_AREA`.
- `H_AREA`, 256, number of active pixels; contention applies when `hc_a < H_AREA`.
- `CONT_ADVANCE`, 0, pixel offset added to `hc` before window decode (9-bit wrap).

Ports (reset `rst_n`: asynchronous, active-low; clock `clk14`):
- `clk14`  in  1  14 MHz master clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `hc0`  in  10  half-pixel counter; `hc = hc0[9:1]`; `hc0[1]` is the free-running CPU clock phase.
- `vc`  in  9  line counter.
- `a15`, `a14`, `a0`  in  1 each  CPU address bits.
- `n_mreq`, `n_iorq`, `n_rfsh`  in  1 each  Z80 strobes, active-low.
- `rambank`  in  3  bank currently paged at 0xC000.
- `cont_en`  in  1  contention enable; when 0, no stalls are ever started.
- `clkcpu`  out  1  registered CPU clock; reset 0.
- `stall`  out  1  high while the CPU clock is frozen; reset 0.
- `vid_slot`  out  1  high while the current slot belongs to the screen fetcher; reset 0.

## Operation
- Window: `hc_a = hc + CONT_ADVANCE`. `win = (vc < V_AREA) && (hc_a < H_AREA) && (hc_a[3:0] < 12)`. `vid_slot` is `win` registered.
- Contended address: `addr_cont = (~a15 & a14) | (a15 & a14 & rambank[0])`, i.e. bank 5 at 0x4000 and odd banks at 0xC000.
- Request: `req = cont_en & n_rfsh & ((~n_mreq & addr_cont) | (~n_iorq & ~a0))`.
- Decision point `dp`: the `clk14` cycle with `hc0[1:0] == 2'b11`, where `clkcpu` would fall next.
- FSM states:
  - RUN: `clkcpu` follows `hc0[1]` with one-cycle delay. At `dp`, if `req & win`, go to STALL. At `dp`, if `req & ~win`, go to SERVED.
  - STALL: `clkcpu` held 1 and `stall` = 1. At each `dp`, if `~win`, go to SERVED and release (`clkcpu` falls in phase).
  - SERVED: same clock behaviour as RUN. Return to RUN when both `n_mreq` and `n_iorq` are high. No new stall is started while in SERVED, so each access is stretched at most once.
- Stalls are whole T-states (4 `clk14`). CPU clock phase relative to `hc0[1]` is preserved after release.
- Simultaneous events:
  - `req` deasserting during STALL does not release the stall early; only `~win` at `dp` releases it.
  - `cont_en` falling during STALL releases at the next `dp`.
- Reset mid-stall: all state returns to RUN immediately; outputs go to 0. After reset release, `clkcpu` resumes following `hc0[1]` on the next cycle.

## Timing
- `clkcpu` is registered: the RUN value equals the previous cycle's `hc0[1]`.
- The stall decision at `dp` takes effect on the next `clk14` edge, so `clkcpu` stays 1 instead of falling.
- Stall length in T-states, for a request at `hc_a[3:0]` = 0, 2, 4, 6, 8, 10, 12, 14: 6, 5, 4, 3, 2, 1, 0, 0.
- `vid_slot` lags `win` by 1 `clk14`.
- `stall` rises with the held-high `clkcpu` cycle and falls on the cycle `clkcpu` falls.

## Test plan
- Reset asserted at `hc0 = 0x05A` during STALL → `clkcpu`, `stall`, `vid_slot` = 0 immediately. After release, `clkcpu` tracks `hc0[1]` delayed by 1 cycle and no stall occurs.
- Memory read at 0x4000, `vc = 10`, `dp` at `hc = 0` → `clkcpu` high for 24 extra `clk14` (6 T-states). `stall` = 1 for the same span, then the normal 4-cycle period resumes.
- Sweep the request across `hc[3:0]` = 0..14 step 2 on line 50 → stall lengths 6, 5, 4, 3, 2, 1, 0, 0 T-states.
- Access to 0xC000 with `rambank` = 4 vs 5, and to 0x8000; also IN with A0=1 vs A0=0 → stall only for `rambank` = 5 and A0=0.
- Same contended access at `vc = 200`, at `hc = 300`, with `cont_en` = 0, and during refresh (`n_rfsh` = 0) → zero stall in every case.
- Hold `n_mreq` low across two consecutive windows (SERVED path) → exactly one stall. A second stall occurs only after `n_mreq` returns high and reasserts.
